mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Parametrised HI/LO multiply/divide unit for the MIPS EX stage. Supersedes the fixed 32-bit unit.
//  Adds: a WIDTH generic, a configurable multiply latency, a real iterative radix-2 divider,
//  multiply-accumulate ops (madd/maddu/msub/msubu) and a cancel input for exception flush.
//  The decoder drives op/start; the hazard unit stalls md-class instructions while busy=1.
// PARAMETERS
//  WIDTH    32  operand, HI and LO width (>=4)
//  MUL_LAT  5   cycles from start edge to HI/LO update for mult-class ops (>=1)
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous active-high reset
//  start   in   1      op valid this cycle
//  op      in   4      0 nop,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd,8 maddu,9 msub,10 msubu; 11-15 = nop
//  src_a   in   WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
//  src_b   in   WIDTH  rt operand (divisor / multiplier)
//  cancel  in   1      abort in-flight op (exception flush)
//  busy    out  1      registered; 1 while an op is in flight
//  done    out  1      1-cycle pulse in the cycle HI/LO first show a new mult/div result
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async): hi=lo=0, busy=0, done=0, FSM=IDLE, counters=0.
//  FSM: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX. busy = (state!=IDLE). No combinational input->busy path.
//  Acceptance: start && op!=0 sampled in IDLE only. start while busy is ignored; the hazard unit guarantees it never occurs.
//  mthi/mtlo (IDLE only): hi<=src_a or lo<=src_a at that edge. No busy, no done.
//  MUL class, ops 1,2,7-10:
//   - Full 2*WIDTH product at the start edge; signed for 1,7,9, unsigned for 2,8,10.
//   - madd/maddu: acc = {hi,lo} + product. msub/msubu: acc = {hi,lo} - product.
//     {hi,lo} is sampled at the start edge. Arithmetic is mod 2^(2*WIDTH).
//   - Result is held internally. FSM->MUL, count=MUL_LAT.
//   - Each edge decrements count. At the edge where count==1: {hi,lo}<=result, done<=1, FSM->IDLE.
//   - busy is high for exactly MUL_LAT cycles.
//  DIV class, ops 3,4:
//   - Operands are latched at the start edge.
//   - DIV_PREP (1 cycle): take magnitudes for signed div.
//   - DIV_ITER (WIDTH cycles): restoring shift-subtract, one quotient bit per cycle.
//   - DIV_FIX (1 cycle): apply signs. Quotient truncates toward zero; remainder takes the dividend's sign.
//     Then hi<=rem, lo<=quot, done<=1, FSM->IDLE.
//   - busy is high for WIDTH+2 cycles (34 at default).
//   - Divisor 0: full latency still runs, hi/lo unchanged, done still pulses.
//   - Signed MIN/-1: lo=MIN (0x80000000), hi=0.
//  hi/lo change only at completion, all bits in one edge. Intermediate values never reach the outputs.
//  cancel: in any non-IDLE state it wins over the completion edge.
//   - FSM->IDLE, no hi/lo write, no done, busy=0 next cycle.
//   - cancel in IDLE blocks acceptance of that cycle's start (incl. mthi/mtlo).
//  Reset mid-op: async clear as above. The partial result is discarded.
// TESTING
//  1 mult src_a=0xFFFFFFFE, src_b=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle
//  2 multu same operands -> hi=0x00000002, lo=0xFFFFFFFA
//  3 div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 34 busy cycles
//    divu 7/0 -> hi/lo unchanged, done pulses
//  4 mthi 0x1, mtlo 0x0, then madd 0xFFFFFFFF*0xFFFFFFFF -> hi=0x1, lo=0x1
//    then msubu 2*3 -> hi=0x0, lo=0xFFFFFFFB
//  5 div started, cancel on busy cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done
//    new mult accepted the cycle after
//  6 reset asserted mid-mult, async (between edges) -> hi=lo=0, busy=0 immediately
//    start during busy ignored
//    MUL_LAT=1, WIDTH=16 build: mult 0x8000*0x8000 -> hi=0x4000, lo=0x0000 after 1 cycle

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   HI/LO multiply/divide unit for the EX stage. Multiplies are computed in
//   full at the start edge and held for MUL_LAT cycles so that their timing
//   matches a pipelined multiplier. Divides run a restoring shift-subtract
//   loop that produces one quotient bit per cycle. madd/msub accumulate into
//   {hi,lo}, and cancel flushes an in-flight op without touching HI/LO.
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset
//   start   : op valid this cycle (accepted only while idle)
//   op      : 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 nop
//   src_a   : rs operand (dividend / multiplicand / mthi-mtlo data)
//   src_b   : rt operand (divisor / multiplier)
//   cancel  : abort the in-flight op, or block this cycle's start when idle
//   busy    : high while an op is in flight (decoded from the state register)
//   done    : one-cycle pulse when HI/LO first show a new mult/div result
//   hi, lo  : HI and LO registers
module mul_div_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
   localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV_PREP,
      S_DIV_ITER,
      S_DIV_FIX
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [CW-1:0]      r_count;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_mulResult;

   // Divider working registers: r_quot first holds the dividend and shifts
   // quotient bits in from the bottom as the dividend bits leave the top.
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_rem;
   logic               r_divSigned;
   logic               r_negQ;
   logic               r_negR;
   logic               r_divZero;

   logic               w_mulLoad;
   logic               w_divLoad;
   logic               w_mthi;
   logic               w_mtlo;
   logic               w_mulFinish;
   logic               w_divFinish;

   logic               w_isMul;
   logic               w_isDiv;
   logic               w_mulSigned;
   logic               w_isAcc;
   logic               w_isSub;
   logic [2*WIDTH-1:0] w_extA;
   logic [2*WIDTH-1:0] w_extB;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_hiLo;
   logic [2*WIDTH-1:0] w_mulResult;

   logic [WIDTH:0]     w_shifted;
   logic               w_fits;
   logic [WIDTH-1:0]   w_sub;
   logic [WIDTH-1:0]   w_quotFixed;
   logic [WIDTH-1:0]   w_remFixed;

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

   // Opcode classification for the multiply datapath and the FSM.
   assign w_isMul     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                        (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   assign w_isDiv     = (op == OP_DIV) || (op == OP_DIVU);
   assign w_mulSigned = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   assign w_isAcc     = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   assign w_isSub     = (op == OP_MSUB) || (op == OP_MSUBU);

   // Sign- or zero-extending both operands to 2*WIDTH lets one unsigned
   // multiply, truncated to 2*WIDTH, serve both signed and unsigned ops.
   assign w_extA    = {{WIDTH{w_mulSigned & src_a[WIDTH-1]}}, src_a};
   assign w_extB    = {{WIDTH{w_mulSigned & src_b[WIDTH-1]}}, src_b};
   assign w_product = w_extA * w_extB;
   assign w_hiLo    = {r_hi, r_lo};

   // Accumulating ops fold the product into the current {hi,lo} at the
   // start edge, so the held result already contains the accumulation.
   always_comb begin
      w_mulResult = w_product;
      if (w_isAcc) begin
         if (w_isSub) begin
            w_mulResult = w_hiLo - w_product;
         end else begin
            w_mulResult = w_hiLo + w_product;
         end
      end
   end

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor only when it fits. The shifted value
   // keeps one extra bit because the remainder can exceed half the divisor
   // range before the shift.
   assign w_shifted = {r_rem, r_quot[WIDTH-1]};
   assign w_fits    = (w_shifted >= {1'b0, r_divisor});
   assign w_sub     = w_shifted[WIDTH-1:0] - r_divisor;

   // The quotient truncates toward zero and the remainder follows the
   // dividend's sign. MIN / -1 falls out naturally: the magnitude 2^(WIDTH-1)
   // negates back to MIN with a zero remainder.
   assign w_quotFixed = r_negQ ? -r_quot : r_quot;
   assign w_remFixed  = r_negR ? -r_rem : r_rem;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and control strobes. Ops are accepted only in IDLE,
   // and cancel takes priority over everything, including the completion
   // edge of a busy state.
   always_comb begin
      w_nextState = r_state;
      w_mulLoad   = 1'b0;
      w_divLoad   = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      w_mulFinish = 1'b0;
      w_divFinish = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !cancel) begin
               if (w_isMul) begin
                  w_mulLoad   = 1'b1;
                  w_nextState = S_MUL;
               end else if (w_isDiv) begin
                  w_divLoad   = 1'b1;
                  w_nextState = S_DIV_PREP;
               end else if (op == OP_MTHI) begin
                  w_mthi = 1'b1;
               end else if (op == OP_MTLO) begin
                  w_mtlo = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (cancel) begin
               w_nextState = S_IDLE;
            end else if (r_count == CNT_ONE) begin
               w_mulFinish = 1'b1;
               w_nextState = S_IDLE;
            end
         end
         S_DIV_PREP: begin
            w_nextState = cancel ? S_IDLE : S_DIV_ITER;
         end
         S_DIV_ITER: begin
            if (cancel) begin
               w_nextState = S_IDLE;
            end else if (r_count == CNT_ONE) begin
               w_nextState = S_DIV_FIX;
            end
         end
         S_DIV_FIX: begin
            w_nextState = S_IDLE;
            if (!cancel) begin
               w_divFinish = 1'b1;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Latency counter and the done pulse. The counter is shared between the
   // multiply hold time and the divide iteration count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_mulFinish | w_divFinish;
         if (w_mulLoad) begin
            r_count <= MUL_CNT;
         end else if (r_state == S_DIV_PREP) begin
            r_count <= DIV_CNT;
         end else if (((r_state == S_MUL) || (r_state == S_DIV_ITER)) && (r_count != '0)) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Multiply result holding register, captured at the start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mulResult <= '0;
      end else if (w_mulLoad) begin
         r_mulResult <= w_mulResult;
      end
   end

   // Divider datapath: latch operands, convert to magnitudes, then iterate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_quot      <= '0;
         r_divisor   <= '0;
         r_rem       <= '0;
         r_divSigned <= 1'b0;
         r_negQ      <= 1'b0;
         r_negR      <= 1'b0;
         r_divZero   <= 1'b0;
      end else if (w_divLoad) begin
         r_quot      <= src_a;
         r_divisor   <= src_b;
         r_divSigned <= (op == OP_DIV);
      end else if (r_state == S_DIV_PREP) begin
         r_quot    <= (r_divSigned && r_quot[WIDTH-1]) ? -r_quot : r_quot;
         r_divisor <= (r_divSigned && r_divisor[WIDTH-1]) ? -r_divisor : r_divisor;
         r_rem     <= '0;
         r_negQ    <= r_divSigned & (r_quot[WIDTH-1] ^ r_divisor[WIDTH-1]);
         r_negR    <= r_divSigned & r_quot[WIDTH-1];
         r_divZero <= (r_divisor == '0);
      end else if (r_state == S_DIV_ITER) begin
         r_rem  <= w_fits ? w_sub : w_shifted[WIDTH-1:0];
         r_quot <= {r_quot[WIDTH-2:0], w_fits};
      end
   end

   // HI/LO architectural registers. Results land in a single edge and only
   // at completion; a zero divisor completes without writing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_mthi) begin
            r_hi <= src_a;
         end
         if (w_mtlo) begin
            r_lo <= src_a;
         end
         if (w_mulFinish) begin
            r_hi <= r_mulResult[2*WIDTH-1:WIDTH];
            r_lo <= r_mulResult[WIDTH-1:0];
         end
         if (w_divFinish && !r_divZero) begin
            r_hi <= w_remFixed;
            r_lo <= w_quotFixed;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed bench for mul_div_unit. A default 32-bit / MUL_LAT=5 instance
//   covers multiply, divide, accumulate, cancel and reset behaviour; a
//   16-bit / MUL_LAT=1 instance covers the narrow, single-cycle build.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cancel;
   logic [3:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        start16;
   logic        cancel16;
   logic [3:0]  op16;
   logic [15:0] srcA16;
   logic [15:0] srcB16;
   logic        busy16;
   logic        done16;
   logic [15:0] hi16;
   logic [15:0] lo16;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(srcA), .src_b(srcB),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   mul_div_unit #(.WIDTH(16), .MUL_LAT(1)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .op(op16), .src_a(srcA16), .src_b(srcB16),
      .cancel(cancel16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
   );

   // Issue one op on the 32-bit instance, then count busy cycles and done
   // pulses until the unit goes idle (bounded) plus one extra cycle.
   task automatic applyStimulus(input logic [3:0] opIn, input logic [31:0] a, input logic [31:0] b,
                                output int busyCycles, output int doneCount);
      @(negedge clk);
      start = 1'b1; op = opIn; srcA = a; srcB = b;
      @(negedge clk);
      start = 1'b0; op = 4'd0; srcA = '0; srcB = '0;
      busyCycles = 0;
      doneCount  = 0;
      while (busy === 1'b1 && busyCycles < 200) begin
         busyCycles++;
         if (done === 1'b1) doneCount++;
         @(negedge clk);
      end
      if (done === 1'b1) doneCount++;
      @(negedge clk);
      if (done === 1'b1) doneCount++;
   endtask

   task automatic applyStimulus16(input logic [3:0] opIn, input logic [15:0] a, input logic [15:0] b,
                                  output int busyCycles, output int doneCount);
      @(negedge clk);
      start16 = 1'b1; op16 = opIn; srcA16 = a; srcB16 = b;
      @(negedge clk);
      start16 = 1'b0; op16 = 4'd0; srcA16 = '0; srcB16 = '0;
      busyCycles = 0;
      doneCount  = 0;
      while (busy16 === 1'b1 && busyCycles < 200) begin
         busyCycles++;
         if (done16 === 1'b1) doneCount++;
         @(negedge clk);
      end
      if (done16 === 1'b1) doneCount++;
      @(negedge clk);
      if (done16 === 1'b1) doneCount++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; srcA = '0; srcB = '0;
      start16 = 1'b0; cancel16 = 1'b0; op16 = '0; srcA16 = '0; srcB16 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      compared++; if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hi: got %h want %h", hi, 32'h0); end
      compared++; if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_lo: got %h want %h", lo, 32'h0); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
   endtask

   task automatic test_mult();
      int bc, dc;
      applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, bc, dc);
      compared++; if (bc != 5) begin mismatched++; $display("[TB] FAIL mult_busy: got %0d want 5", bc); end
      compared++; if (dc != 1) begin mismatched++; $display("[TB] FAIL mult_done: got %0d want 1", dc); end
      compared++; if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL mult_hi: got %h want FFFFFFFF", hi); end
      compared++; if (lo !== 32'hFFFFFFFA) begin mismatched++; $display("[TB] FAIL mult_lo: got %h want FFFFFFFA", lo); end
      applyStimulus(4'd2, 32'hFFFFFFFE, 32'd3, bc, dc);
      compared++; if (hi !== 32'h00000002) begin mismatched++; $display("[TB] FAIL multu_hi: got %h want 00000002", hi); end
      compared++; if (lo !== 32'hFFFFFFFA) begin mismatched++; $display("[TB] FAIL multu_lo: got %h want FFFFFFFA", lo); end
      compared++; if (dc != 1) begin mismatched++; $display("[TB] FAIL multu_done: got %0d want 1", dc); end
   endtask

   task automatic test_div();
      int bc, dc;
      applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, bc, dc);
      compared++; if (bc != 34) begin mismatched++; $display("[TB] FAIL div_busy: got %0d want 34", bc); end
      compared++; if (dc != 1) begin mismatched++; $display("[TB] FAIL div_done: got %0d want 1", dc); end
      compared++; if (lo !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_neg_lo: got %h want FFFFFFFD", lo); end
      compared++; if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div_neg_hi: got %h want FFFFFFFF", hi); end
      applyStimulus(4'd3, 32'd7, 32'hFFFFFFFE, bc, dc);
      compared++; if (lo !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_negdiv_lo: got %h want FFFFFFFD", lo); end
      compared++; if (hi !== 32'h00000001) begin mismatched++; $display("[TB] FAIL div_negdiv_hi: got %h want 00000001", hi); end
      applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, bc, dc);
      compared++; if (lo !== 32'h80000000) begin mismatched++; $display("[TB] FAIL div_min_lo: got %h want 80000000", lo); end
      compared++; if (hi !== 32'h00000000) begin mismatched++; $display("[TB] FAIL div_min_hi: got %h want 00000000", hi); end
      applyStimulus(4'd4, 32'd100, 32'd7, bc, dc);
      compared++; if (lo !== 32'd14) begin mismatched++; $display("[TB] FAIL divu_lo: got %h want 0000000E", lo); end
      compared++; if (hi !== 32'd2) begin mismatched++; $display("[TB] FAIL divu_hi: got %h want 00000002", hi); end
      applyStimulus(4'd4, 32'd7, 32'd0, bc, dc);
      compared++; if (bc != 34) begin mismatched++; $display("[TB] FAIL div0_busy: got %0d want 34", bc); end
      compared++; if (dc != 1) begin mismatched++; $display("[TB] FAIL div0_done: got %0d want 1", dc); end
      compared++; if (lo !== 32'd14) begin mismatched++; $display("[TB] FAIL div0_lo: got %h want 0000000E", lo); end
      compared++; if (hi !== 32'd2) begin mismatched++; $display("[TB] FAIL div0_hi: got %h want 00000002", hi); end
   endtask

   task automatic test_mac();
      int bc, dc;
      applyStimulus(4'd5, 32'h1, 32'h0, bc, dc);
      compared++; if (bc != 0) begin mismatched++; $display("[TB] FAIL mthi_busy: got %0d want 0", bc); end
      compared++; if (dc != 0) begin mismatched++; $display("[TB] FAIL mthi_done: got %0d want 0", dc); end
      applyStimulus(4'd6, 32'h0, 32'h0, bc, dc);
      compared++; if (hi !== 32'h1) begin mismatched++; $display("[TB] FAIL mthi_hi: got %h want 00000001", hi); end
      compared++; if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL mtlo_lo: got %h want 00000000", lo); end
      applyStimulus(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
      compared++; if (bc != 5) begin mismatched++; $display("[TB] FAIL madd_busy: got %0d want 5", bc); end
      compared++; if (hi !== 32'h1) begin mismatched++; $display("[TB] FAIL madd_hi: got %h want 00000001", hi); end
      compared++; if (lo !== 32'h1) begin mismatched++; $display("[TB] FAIL madd_lo: got %h want 00000001", lo); end
      applyStimulus(4'd10, 32'd2, 32'd3, bc, dc);
      compared++; if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL msubu_hi: got %h want 00000000", hi); end
      compared++; if (lo !== 32'hFFFFFFFB) begin mismatched++; $display("[TB] FAIL msubu_lo: got %h want FFFFFFFB", lo); end
      applyStimulus(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
      compared++; if (hi !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL maddu_hi: got %h want FFFFFFFE", hi); end
      compared++; if (lo !== 32'hFFFFFFFC) begin mismatched++; $display("[TB] FAIL maddu_lo: got %h want FFFFFFFC", lo); end
   endtask

   task automatic test_cancel();
      int cyc;
      int guard;
      logic sawDone;
      @(negedge clk);
      start = 1'b1; op = 4'd3; srcA = 32'd100; srcB = 32'd7;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      cyc = 1;
      sawDone = 1'b0;
      while (cyc < 10 && busy === 1'b1) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
         cyc++;
      end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL cancel_prebusy: got %b want 1", busy); end
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      if (done === 1'b1) sawDone = 1'b1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL cancel_busy: got %b want 0", busy); end
      compared++; if (sawDone !== 1'b0) begin mismatched++; $display("[TB] FAIL cancel_done: got %b want 0", sawDone); end
      compared++; if (hi !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL cancel_hi: got %h want FFFFFFFE", hi); end
      compared++; if (lo !== 32'hFFFFFFFC) begin mismatched++; $display("[TB] FAIL cancel_lo: got %h want FFFFFFFC", lo); end
      start = 1'b1; op = 4'd1; srcA = 32'd5; srcB = 32'd6;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL cancel_newop_busy: got %b want 1", busy); end
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      compared++; if (lo !== 32'd30) begin mismatched++; $display("[TB] FAIL cancel_newop_lo: got %h want 0000001E", lo); end
      compared++; if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL cancel_newop_hi: got %h want 00000000", hi); end
      // cancel while idle must block mthi/mtlo
      @(negedge clk);
      start = 1'b1; op = 4'd5; srcA = 32'h1234; cancel = 1'b1;
      @(negedge clk);
      op = 4'd6; srcA = 32'hABCD;
      @(negedge clk);
      start = 1'b0; op = 4'd0; srcA = '0; cancel = 1'b0;
      @(negedge clk);
      compared++; if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL idle_cancel_hi: got %h want 00000000", hi); end
      compared++; if (lo !== 32'd30) begin mismatched++; $display("[TB] FAIL idle_cancel_lo: got %h want 0000001E", lo); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      start = 1'b1; op = 4'd1; srcA = 32'd2; srcB = 32'd3;
      @(negedge clk);
      op = 4'd3; srcA = 32'd9; srcB = 32'd1;
      cyc = 1;
      @(negedge clk);
      start = 1'b0; op = 4'd0; srcA = '0; srcB = '0;
      cyc++;
      while (busy === 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      compared++; if (cyc != 6) begin mismatched++; $display("[TB] FAIL ignore_busy_len: got %0d want 6", cyc); end
      compared++; if (lo !== 32'd6) begin mismatched++; $display("[TB] FAIL ignore_lo: got %h want 00000006", lo); end
      @(negedge clk);
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_noqueue: got %b want 0", busy); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1; op = 4'd1; srcA = 32'd7; srcB = 32'd7;
      @(negedge clk);
      start = 1'b0; op = 4'd0; srcA = '0; srcB = '0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_busy: got %b want 0", busy); end
      compared++; if (lo !== 32'd0) begin mismatched++; $display("[TB] FAIL areset_lo: got %h want 00000000", lo); end
      compared++; if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL areset_hi: got %h want 00000000", hi); end
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      compared++; if (lo !== 32'd0) begin mismatched++; $display("[TB] FAIL areset_discard_lo: got %h want 00000000", lo); end
   endtask

   task automatic test_width16();
      int bc, dc;
      applyStimulus16(4'd1, 16'h8000, 16'h8000, bc, dc);
      compared++; if (bc != 1) begin mismatched++; $display("[TB] FAIL w16_mult_busy: got %0d want 1", bc); end
      compared++; if (dc != 1) begin mismatched++; $display("[TB] FAIL w16_mult_done: got %0d want 1", dc); end
      compared++; if (hi16 !== 16'h4000) begin mismatched++; $display("[TB] FAIL w16_mult_hi: got %h want 4000", hi16); end
      compared++; if (lo16 !== 16'h0000) begin mismatched++; $display("[TB] FAIL w16_mult_lo: got %h want 0000", lo16); end
      applyStimulus16(4'd3, 16'hFF9C, 16'd7, bc, dc);
      compared++; if (bc != 18) begin mismatched++; $display("[TB] FAIL w16_div_busy: got %0d want 18", bc); end
      compared++; if (lo16 !== 16'hFFF2) begin mismatched++; $display("[TB] FAIL w16_div_lo: got %h want FFF2", lo16); end
      compared++; if (hi16 !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL w16_div_hi: got %h want FFFE", hi16); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mac();
      test_cancel();
      test_back_to_back();
      test_async_reset();
      test_width16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
